// File: rtl/spi_reader.sv
// SPI mode-0 slave without chip select: oversamples spi_clk/mosi in the clk domain,
// assembles WIDTH-bit frames on data and shifts toOutput out on miso.
module spi_reader #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             spi_clk,
   input  logic             mosi,
   output logic             miso,
   input  logic [WIDTH-1:0] toOutput,
   output logic [WIDTH-1:0] data,
   output logic             received
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [SYNC_STAGES-1:0] sclk_sync_reg;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;
   logic                   sclk_prev_reg;
   logic                   sclk_sync;
   logic                   mosi_sync;
   logic                   rise;
   logic                   fall;

   logic [CNT_W-1:0] bit_cnt_reg,  bit_cnt_next;
   logic [WIDTH-2:0] rx_shift_reg, rx_shift_next;
   logic [WIDTH-1:0] tx_shift_reg, tx_shift_next;
   logic [WIDTH-1:0] data_reg,     data_next;
   logic             received_reg, received_next;
   logic [WIDTH-1:0] rx_full;

   // Both lines see the same number of stages so the bit and its edge stay aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_reg <= '0;
         mosi_sync_reg <= '0;
         sclk_prev_reg <= 1'b0;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
         sclk_prev_reg <= sclk_sync;
      end
   end

   assign sclk_sync = sclk_sync_reg[SYNC_STAGES-1];
   assign mosi_sync = mosi_sync_reg[SYNC_STAGES-1];
   assign rise      = sclk_sync & ~sclk_prev_reg;
   assign fall      = ~sclk_sync & sclk_prev_reg;
   assign rx_full   = {rx_shift_reg, mosi_sync};

   always_comb begin
      bit_cnt_next  = bit_cnt_reg;
      rx_shift_next = rx_shift_reg;
      tx_shift_next = tx_shift_reg;
      data_next     = data_reg;
      received_next = 1'b0;

      if (rise) begin
         rx_shift_next = rx_full[WIDTH-2:0];
         if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next  = '0;
            data_next     = rx_full;
            received_next = 1'b1;
         end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
         end
      end

      // Between frames the transmit register follows toOutput so the MSB is
      // already on miso when the master first raises spi_clk.
      if ((bit_cnt_reg == '0) && !rise) begin
         tx_shift_next = toOutput;
      end else if (fall && (bit_cnt_reg != '0)) begin
         tx_shift_next = {tx_shift_reg[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_reg  <= '0;
         rx_shift_reg <= '0;
         tx_shift_reg <= '0;
         data_reg     <= '0;
         received_reg <= 1'b0;
      end else begin
         bit_cnt_reg  <= bit_cnt_next;
         rx_shift_reg <= rx_shift_next;
         tx_shift_reg <= tx_shift_next;
         data_reg     <= data_next;
         received_reg <= received_next;
      end
   end

   assign miso     = tx_shift_reg[WIDTH-1];
   assign data     = data_reg;
   assign received = received_reg;

endmodule

// File: tb/tb_spi_reader.sv
// Directed bench for spi_reader: reset, two frames with miso capture, an aborted
// partial frame followed by a clean frame, and an idle period.
module tb_spi_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spi_clk = 1'b0;
   logic       mosi = 1'b0;
   logic       miso;
   logic [7:0] toOutput = 8'h00;
   logic [7:0] data;
   logic       received;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int cyc = 0;
   int rcv_cnt = 0;
   int recv_cyc = 0;
   int last_rise_cyc = 0;

   spi_reader #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .spi_clk  (spi_clk),
      .mosi     (mosi),
      .miso     (miso),
      .toOutput (toOutput),
      .data     (data),
      .received (received)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (received) begin
         rcv_cnt++;
         recv_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Master side: sends the first nbits of b MSB first, half clk per phase,
   // capturing miso just before each rising edge.
   task automatic send_bits(input logic [7:0] b, input int nbits, input int half,
                            input int chg_after, input logic [7:0] chg_val,
                            output logic [7:0] mbits, output int pulses_before_last);
      mbits = 8'h00;
      pulses_before_last = rcv_cnt;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_clk = 1'b0;
         mosi    = b[i];
         repeat (half) @(posedge clk);
         #1;
         mbits[i] = miso;
         pulses_before_last = rcv_cnt;
         spi_clk = 1'b1;
         last_rise_cyc = cyc;
         repeat (half) @(posedge clk);
         #1;
         if (8 - i == chg_after) toOutput = chg_val;
      end
      spi_clk = 1'b0;
   endtask

   logic [7:0] mbits;
   int         pre_last;
   int         base;

   initial begin
      // Reset
      toOutput = 8'b10101011;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_received", 32'(received), 32'h0);
      chk("rst_miso", 32'(miso), 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_miso", 32'(miso), 32'h1);
      repeat (2) @(posedge clk);
      #1;

      // Frame 1: toOutput swapped after the 6th bit must not disturb this frame
      base = rcv_cnt;
      send_bits(8'b11001011, 8, 4, 6, 8'b00001010, mbits, pre_last);
      repeat (4) @(posedge clk);
      #1;
      chk("f1_data", 32'(data), 32'hCB);
      chk("f1_pulses", 32'(rcv_cnt - base), 32'd1);
      chk("f1_latency_ok", 32'((recv_cyc - last_rise_cyc) >= 1 && (recv_cyc - last_rise_cyc) <= 4), 32'h1);
      chk("f1_miso", 32'(mbits), 32'b10101011);

      // Gap then frame 2
      chk("gap_data", 32'(data), 32'hCB);
      base = rcv_cnt;
      send_bits(8'b11110000, 8, 4, 0, 8'h00, mbits, pre_last);
      chk("f2_no_early_pulse", 32'(pre_last - base), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("f2_data", 32'(data), 32'hF0);
      chk("f2_pulses", 32'(rcv_cnt - base), 32'd1);
      chk("f2_miso", 32'(mbits), 32'b00001010);

      // Partial frame, then reset mid-stream
      base = rcv_cnt;
      send_bits(8'b10100000, 3, 2, 0, 8'h00, mbits, pre_last);
      repeat (4) @(posedge clk);
      #1;
      chk("partial_data_held", 32'(data), 32'hF0);
      chk("partial_no_pulse", 32'(rcv_cnt - base), 32'd0);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst2_data", 32'(data), 32'h00);
      chk("rst2_miso", 32'(miso), 32'h0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Full frame at minimum phase timing after the reset
      base = rcv_cnt;
      send_bits(8'h5A, 8, 2, 0, 8'h00, mbits, pre_last);
      chk("f3_no_early_pulse", 32'(pre_last - base), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("f3_data", 32'(data), 32'h5A);
      chk("f3_pulses", 32'(rcv_cnt - base), 32'd1);
      chk("f3_latency_ok", 32'((recv_cyc - last_rise_cyc) >= 1 && (recv_cyc - last_rise_cyc) <= 4), 32'h1);

      // Idle: miso tracks toOutput MSB, nothing received
      base = rcv_cnt;
      toOutput = 8'h80;
      repeat (7) @(posedge clk);
      #1;
      chk("idle_miso_a", 32'(miso), 32'h1);
      toOutput = 8'h7F;
      repeat (7) @(posedge clk);
      #1;
      chk("idle_miso_b", 32'(miso), 32'h0);
      toOutput = 8'hC0;
      repeat (7) @(posedge clk);
      #1;
      chk("idle_miso_c", 32'(miso), 32'h1);
      chk("idle_no_pulse", 32'(rcv_cnt - base), 32'd0);
      chk("idle_data", 32'(data), 32'h5A);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
